// File: rtl/ccd_capture_sequencer_if.sv
// Signal bundle between the CCD timing front end and the capture sequencer.
// master drives the sync/request inputs, slave is the sequencer.
interface ccd_capture_sequencer_if #(
  parameter int FRAME_CNT_W = 32,
  parameter int LINE_CNT_W  = 12
);
  // There is no valid/ready handshake. iSTART/iSTOP/iSNAP are levels: only their
  // rising edge is a request. iFVAL/iLVAL are sampled on every iCLK with no backpressure.
  logic                   iFVAL;
  logic                   iLVAL;
  logic                   iSTART;
  logic                   iSTOP;
  logic                   iSNAP;
  logic                   iCLR;
  logic                   oCAPTURE_EN;
  logic                   oBUSY;
  logic                   oFRAME_DONE;
  logic [FRAME_CNT_W-1:0] oFrame_Count;
  logic [LINE_CNT_W-1:0]  oLine_Count;
  logic [1:0]             oSTATE;
  logic                   oERR;

  modport master (
    output iFVAL, iLVAL, iSTART, iSTOP, iSNAP, iCLR,
    input  oCAPTURE_EN, oBUSY, oFRAME_DONE, oFrame_Count, oLine_Count, oSTATE, oERR
  );

  modport slave (
    input  iFVAL, iLVAL, iSTART, iSTOP, iSNAP, iCLR,
    output oCAPTURE_EN, oBUSY, oFRAME_DONE, oFrame_Count, oLine_Count, oSTATE, oERR
  );
endinterface

// File: rtl/ccd_capture_sequencer.sv
// Frame-aligned start/stop/snapshot gate for the CCD capture path (pixel-clock domain).
// Define CCD_SEQ_WATCHDOG_EN to build the FVAL-inactivity watchdog that drives oERR.
module ccd_capture_sequencer #(
  parameter int FRAME_CNT_W = 32,
  parameter int LINE_CNT_W  = 12,
  parameter int SNAP_FRAMES = 1,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int TIMEOUT_W   = 24
) (
  input logic iCLK,
  input logic iRST_N,
  ccd_capture_sequencer_if.slave bus
);

  localparam int REM_W = (SNAP_FRAMES > 1) ? $clog2(SNAP_FRAMES + 1) : 1;

  if (SNAP_FRAMES < 1 || (TIMEOUT_CYC >> TIMEOUT_W) != 0) begin : g_bad_cfg
    $error("ccd_capture_sequencer: SNAP_FRAMES must be >= 1 and TIMEOUT_CYC must fit in TIMEOUT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic                   start_d, stop_d, snap_d, fval_d, lval_d;
  logic                   start_e, stop_e, snap_e, fs, fe, ls;
  logic                   snap_mode;
  logic [REM_W-1:0]       remaining;
  logic                   frame_done_c, cap_en_c, line_clr_c, line_inc_c, wd_timeout;
  logic                   cap_en_q, busy_q, done_q;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [LINE_CNT_W-1:0]  line_cnt;

  assign start_e = bus.iSTART & ~start_d;
  assign stop_e  = bus.iSTOP  & ~stop_d;
  assign snap_e  = bus.iSNAP  & ~snap_d;
  assign fs      = bus.iFVAL  & ~fval_d;
  assign fe      = ~bus.iFVAL & fval_d;
  assign ls      = bus.iLVAL  & ~lval_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      start_d <= 1'b0;
      stop_d  <= 1'b0;
      snap_d  <= 1'b0;
      fval_d  <= 1'b0;
      lval_d  <= 1'b0;
    end else begin
      start_d <= bus.iSTART;
      stop_d  <= bus.iSTOP;
      snap_d  <= bus.iSNAP;
      fval_d  <= bus.iFVAL;
      lval_d  <= bus.iLVAL;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    frame_done_c = 1'b0;
    case (state)
      IDLE:    if (snap_e || start_e) state_next = ARMED;
      ARMED: begin
        if (stop_e)  state_next = IDLE;
        else if (fs) state_next = CAPTURE;
      end
      CAPTURE: begin
        // A stop coinciding with frame end still counts the frame that just closed.
        if (fe) begin
          frame_done_c = 1'b1;
          if ((snap_mode && remaining == REM_W'(1)) || stop_e) state_next = IDLE;
        end else if (stop_e) begin
          state_next = bus.iFVAL ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (fe) begin
          frame_done_c = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (wd_timeout) begin
      state_next   = IDLE;
      frame_done_c = 1'b0;
    end
  end

  always_comb begin
    cap_en_c   = (state_next == CAPTURE || state_next == DRAIN) && bus.iFVAL;
    line_clr_c = fs && (state_next == CAPTURE || state_next == DRAIN);
    line_inc_c = ls && (state == CAPTURE || state == DRAIN) && (line_cnt != '1);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cap_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      frame_cnt <= '0;
      line_cnt  <= '0;
      snap_mode <= 1'b0;
      remaining <= '0;
    end else begin
      cap_en_q <= cap_en_c;
      busy_q   <= (state_next != IDLE);
      done_q   <= frame_done_c;
      if (bus.iCLR)          frame_cnt <= '0;
      else if (frame_done_c) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      if (line_clr_c)        line_cnt <= '0;
      else if (line_inc_c)   line_cnt <= line_cnt + LINE_CNT_W'(1);
      if (state == IDLE) begin
        if (snap_e) begin
          snap_mode <= 1'b1;
          remaining <= REM_W'(SNAP_FRAMES);
        end else if (start_e) begin
          snap_mode <= 1'b0;
        end
      end else if (state == CAPTURE && fe && snap_mode) begin
        remaining <= remaining - REM_W'(1);
      end
    end
  end

`ifdef CCD_SEQ_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 err_q;

  // The counter restarts on any FVAL edge or state change, so it measures a stuck state.
  assign wd_timeout = (state != IDLE) && !(fs || fe) && (wd_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE || state_next != state || fs || fe) wd_cnt <= '0;
      else                                                  wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      if (bus.iCLR)                                   err_q <= 1'b0;
      else if (wd_timeout)                            err_q <= 1'b1;
      else if (state == IDLE && (start_e || snap_e))  err_q <= 1'b0;
    end
  end

  assign bus.oERR = err_q;
`else
  assign wd_timeout = 1'b0;
  assign bus.oERR   = 1'b0;
`endif

  assign bus.oCAPTURE_EN  = cap_en_q;
  assign bus.oBUSY        = busy_q;
  assign bus.oFRAME_DONE  = done_q;
  assign bus.oFrame_Count = frame_cnt;
  assign bus.oLine_Count  = line_cnt;
  assign bus.oSTATE       = state;

endmodule
